// File: rtl/branch_pc_unit_pkg.sv
// ------------------------------------------------------------------
// branch_pc_unit_pkg: shared opcodes, widths and state encoding.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package branch_pc_unit_pkg;

  localparam int PC_W  = 32;
  localparam int IMM_W = 16;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic is_cond_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_pc_unit_branch_target_calc.sv
// ------------------------------------------------------------------
// branch_target_calc: branch (PC-relative) and jump (region) targets.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module branch_target_calc
  import branch_pc_unit_pkg::*;
(
  input  logic [PC_W-1:0]  ex_pc_plus4,
  input  logic [IMM_W-1:0] immediate,
  input  logic [PC_W-1:0]  id_pc_plus4,
  input  logic [25:0]      jump_index,
  output logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  jmp_target
);

  logic [PC_W-1:0] br_offset;
  logic            unused_id_low;

  // Word offset: sign-extend then scale by 4; the add wraps silently.
  assign br_offset  = {{(PC_W-IMM_W-2){immediate[IMM_W-1]}}, immediate, 2'b00};
  assign br_target  = ex_pc_plus4 + br_offset;
  assign jmp_target = {id_pc_plus4[31:28], jump_index, 2'b00};

  assign unused_id_low = ^id_pc_plus4[27:0];

endmodule

`default_nettype wire

// File: rtl/branch_pc_unit.sv
// ------------------------------------------------------------------
// branch_pc_unit: fetch PC register, next-PC select, flush and drain control.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [5:0]        opcode_ex,
  input  logic              sig_branch,
  input  logic [PC_W-1:0]   ex_pc_plus4,
  input  logic [IMM_W-1:0]  immediate_ex,
  input  logic              jump_id,
  input  logic [25:0]       jump_index,
  input  logic [PC_W-1:0]   id_pc_plus4,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              branch_taken,
  output logic [15:0]       taken_count
);

  localparam logic [2:0] DRAIN_INIT = 3'(FLUSH_CYCLES - 1);

  logic [PC_W-1:0] pc_q, pc_d;
  state_e          state_q, state_d;
  logic [2:0]      drain_cnt_q, drain_cnt_d;
  logic            flush_if_id_q, flush_if_id_d;
  logic            flush_id_ex_q, flush_id_ex_d;
  logic            branch_taken_q, branch_taken_d;
  logic [15:0]     taken_count_q, taken_count_d;

  logic            br_valid;
  logic            jmp_valid;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;

  branch_target_calc u_target_calc (
    .ex_pc_plus4 (ex_pc_plus4),
    .immediate   (immediate_ex),
    .id_pc_plus4 (id_pc_plus4),
    .jump_index  (jump_index),
    .br_target   (br_target),
    .jmp_target  (jmp_target)
  );

  // Opcode gate comes first so an unknown sig_branch on a non-branch stays out of pc.
  assign br_valid  = is_cond_branch(opcode_ex) && sig_branch && (state_q == ST_RUN);
  assign jmp_valid = jump_id && (state_q == ST_RUN) && !br_valid;

  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    pc_d           = pc_q;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    taken_count_d  = taken_count_q;
    flush_if_id_d  = br_valid | jmp_valid;
    flush_id_ex_d  = br_valid;
    branch_taken_d = br_valid;

    if (br_valid) begin
      pc_d = br_target;
    end else if (jmp_valid && !stall) begin
      pc_d = jmp_target;
    end else if (!stall) begin
      pc_d = pc_plus4;
    end

    if (br_valid) begin
      state_d     = ST_DRAIN;
      drain_cnt_d = DRAIN_INIT;
      if (taken_count_q != 16'hFFFF) begin
        taken_count_d = taken_count_q + 16'd1;
      end
    end else if (state_q == ST_DRAIN && !stall) begin
      if (drain_cnt_q == 3'd0) begin
        state_d = ST_RUN;
      end else begin
        drain_cnt_d = drain_cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      state_q        <= ST_RUN;
      drain_cnt_q    <= 3'd0;
      flush_if_id_q  <= 1'b0;
      flush_id_ex_q  <= 1'b0;
      branch_taken_q <= 1'b0;
      taken_count_q  <= 16'd0;
    end else begin
      pc_q           <= pc_d;
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      flush_if_id_q  <= flush_if_id_d;
      flush_id_ex_q  <= flush_id_ex_d;
      branch_taken_q <= branch_taken_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign pc           = pc_q;
  assign flush_if_id  = flush_if_id_q;
  assign flush_id_ex  = flush_id_ex_q;
  assign branch_taken = branch_taken_q;
  assign taken_count  = taken_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
// ------------------------------------------------------------------
// tb_branch_pc_unit: scoreboard bench with a cycle-level reference model.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_branch_pc_unit;
  import branch_pc_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0020;
  localparam int          FLUSH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [5:0]  opcode_ex;
  logic        sig_branch;
  logic [31:0] ex_pc_plus4;
  logic [15:0] immediate_ex;
  logic        jump_id;
  logic [25:0] jump_index;
  logic [31:0] id_pc_plus4;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        branch_taken;
  logic [15:0] taken_count;

  branch_pc_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .opcode_ex    (opcode_ex),
    .sig_branch   (sig_branch),
    .ex_pc_plus4  (ex_pc_plus4),
    .immediate_ex (immediate_ex),
    .jump_id      (jump_id),
    .jump_index   (jump_index),
    .id_pc_plus4  (id_pc_plus4),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .branch_taken (branch_taken),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fif;
    logic        fie;
    logic        bt;
    logic [15:0] tc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: drain is tracked as "cycles still to be ignored".
  logic [31:0] m_pc;
  int          m_drain;
  int          m_tc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_drain = 0;
    m_tc    = 0;
  endtask

  task automatic drive(input logic [5:0] op, input logic sb, input logic st,
                       input logic [31:0] expc, input logic [15:0] imm,
                       input logic jid, input logic [25:0] jidx, input logic [31:0] idpc);
    exp_t e;
    bit   br;
    bit   jmp;
    int   off;
    @(negedge clk);
    opcode_ex    = op;
    sig_branch   = sb;
    stall        = st;
    ex_pc_plus4  = expc;
    immediate_ex = imm;
    jump_id      = jid;
    jump_index   = jidx;
    id_pc_plus4  = idpc;

    br  = (op == OP_BEQ || op == OP_BNE) && (sb === 1'b1) && (m_drain == 0);
    jmp = (jid === 1'b1) && (m_drain == 0) && !br;
    off = $signed(imm);
    if (br)              m_pc = expc + 32'(off * 4);
    else if (jmp && !st) m_pc = (idpc & 32'hF000_0000) | (32'(jidx) << 2);
    else if (!st)        m_pc = m_pc + 32'd4;
    if (br)                        m_drain = FLUSH;
    else if (m_drain > 0 && !st)   m_drain = m_drain - 1;
    if (br && m_tc < 65535)        m_tc = m_tc + 1;

    e.pc  = m_pc;
    e.fif = br | jmp;
    e.fie = br;
    e.bt  = br;
    e.tc  = 16'(m_tc);
    expq.push_back(e);
  endtask

  task automatic idle(input logic st);
    drive(6'h00, 1'b0, st, 32'h0, 16'h0, 1'b0, 26'h0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_fif"}, 32'(flush_if_id), 32'h0);
    check({tag, "_fie"}, 32'(flush_id_ex), 32'h0);
    check({tag, "_bt"}, 32'(branch_taken), 32'h0);
    check({tag, "_tc"}, 32'(taken_count), 32'h0);
  endtask

  // Asynchronous reset applied between edges; released just after an edge.
  task automatic mid_reset();
    @(negedge clk);
    opcode_ex  = 6'h00;
    sig_branch = 1'b0;
    jump_id    = 1'b0;
    stall      = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_flush_if_id", 32'(flush_if_id), 32'(e.fif));
        check("sb_flush_id_ex", 32'(flush_id_ex), 32'(e.fie));
        check("sb_branch_taken", 32'(branch_taken), 32'(e.bt));
        check("sb_taken_count", 32'(taken_count), 32'(e.tc));
        check("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks", checks);
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1; stall = 1'b0; opcode_ex = 6'h00; sig_branch = 1'b0;
    ex_pc_plus4 = 32'h0; immediate_ex = 16'h0; jump_id = 1'b0;
    jump_index = 26'h0; id_pc_plus4 = 32'h0;
    model_reset();
    #3 check_reset_state("por");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // BEQ not taken from the reset PC
    drive(OP_BEQ, 1'b0, 1'b0, 32'h0000_0050, 16'h0003, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("beq_nt_pc", pc, 32'h0000_0024);
    check("beq_nt_bt", 32'(branch_taken), 32'h0);

    // BEQ taken with a negative offset
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0010, 16'hFFFF, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("beq_t_pc", pc, 32'h0000_000C);
    check("beq_t_fif", 32'(flush_if_id), 32'h1);
    check("beq_t_fie", 32'(flush_id_ex), 32'h1);
    check("beq_t_bt", 32'(branch_taken), 32'h1);
    check("beq_t_tc", 32'(taken_count), 32'h1);
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0500, 16'h0010, 1'b0, 26'h0, 32'h0);
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0500, 16'h0010, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("drain_ignore_pc", pc, 32'h0000_0014);
    check("drain_ignore_bt", 32'(branch_taken), 32'h0);

    // Branch under stall, then a stall held through DRAIN
    drive(OP_BNE, 1'b1, 1'b1, 32'h0000_0100, 16'h0004, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("bne_stall_pc", pc, 32'h0000_0110);
    repeat (3) idle(1'b1);
    after_edge();
    check("stall_hold_pc", pc, 32'h0000_0110);
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0600, 16'h0001, 1'b0, 26'h0, 32'h0);
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0600, 16'h0001, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("stall_drain_pc", pc, 32'h0000_0118);
    check("stall_drain_bt", 32'(branch_taken), 32'h0);
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0200, 16'h0000, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("after_drain_pc", pc, 32'h0000_0200);
    check("after_drain_tc", 32'(taken_count), 32'h3);
    repeat (2) idle(1'b0);

    // Reset while the drain counter is at 1, then RUN straight away
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0040, 16'h0000, 1'b0, 26'h0, 32'h0);
    mid_reset();
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0080, 16'h0000, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("post_rst_pc", pc, 32'h0000_0080);
    check("post_rst_tc", 32'(taken_count), 32'h1);
    repeat (2) idle(1'b0);

    // Jump coincident with a taken branch: branch wins
    drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_0300, 16'h0001, 1'b1, 26'h40, 32'h1000_0008);
    after_edge();
    check("jmp_br_pc", pc, 32'h0000_0304);
    check("jmp_br_fie", 32'(flush_id_ex), 32'h1);
    repeat (2) idle(1'b0);
    drive(6'h00, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 26'h40, 32'h1000_0008);
    after_edge();
    check("jmp_pc", pc, 32'h1000_0100);
    check("jmp_fif", 32'(flush_if_id), 32'h1);
    check("jmp_fie", 32'(flush_id_ex), 32'h0);
    check("jmp_bt", 32'(branch_taken), 32'h0);

    // Target wraps past 2^32
    drive(OP_BNE, 1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0001, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("wrap_pc", pc, 32'h0000_0000);
    repeat (2) idle(1'b0);

    // Unknown sig_branch on a non-branch opcode
    drive(6'h23, 1'bx, 1'b0, 32'h0000_0700, 16'h0008, 1'b0, 26'h0, 32'h0);
    after_edge();
    check("xbr_pc", pc, 32'h0000_000C);
    check("xbr_bt", 32'(branch_taken), 32'h0);

    // Saturation: preload near the top, then keep branching
    force dut.taken_count_q = 16'hFFFD;
    #1 release dut.taken_count_q;
    m_tc = 16'hFFFD;
    check("sat_preload", 32'(taken_count), 32'h0000_FFFD);
    for (int k = 0; k < 4; k++) begin
      drive(OP_BEQ, 1'b1, 1'b0, 32'h0000_1000, 16'(k), 1'b0, 26'h0, 32'h0);
      repeat (FLUSH) idle(1'b0);
    end
    after_edge();
    check("sat_tc", 32'(taken_count), 32'h0000_FFFF);

    // Randomized traffic, with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      int   r;
      logic [5:0] op;
      r  = int'($urandom_range(0, 9));
      op = (r < 3) ? OP_BEQ : (r < 6) ? OP_BNE : (r < 7) ? OP_J : 6'($urandom);
      drive(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            32'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
            26'($urandom), 32'($urandom));
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
